// File: rtl/boot_seq_pkg.sv
// Shared constants for the boot sequencer: state encoding, fetch-source values
// and the supported boot ROM read-latency range.
package boot_seq_pkg;

  localparam logic [2:0] ST_BIOS   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_SWITCH = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic FETCH_BIOS = 1'b0;
  localparam logic FETCH_IMEM = 1'b1;

  // ROM_LATENCY must stay within this range; the copy pipe depth follows it.
  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 4;

endpackage

// File: rtl/boot_copy_pipe.sv
// Valid/index delay line matching the boot ROM read latency; LAT cycles deep,
// no backpressure. pend_o flags entries that will still write after this cycle.
module boot_copy_pipe #(
  parameter int LAT = 1,
  parameter int AW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [AW-1:0] idx_i,
  output logic          vld_o,
  output logic [AW-1:0] idx_o,
  output logic          pend_o
);

  logic [LAT-1:0] vld_q;
  logic [AW-1:0]  idx_q [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  // The output stage is being written this cycle, so only earlier stages count.
  always_comb begin
    pend_o = 1'b0;
    for (int i = 0; i < LAT - 1; i++) pend_o = pend_o | vld_q[i];
  end

  assign vld_o = vld_q[LAT-1];
  assign idx_o = idx_q[LAT-1];

endmodule

// File: rtl/boot_sequencer.sv
// Copies a boot ROM image into instruction memory, then hands fetch to it and owns
// core halt/resume. N words take N+ROM_LATENCY cycles plus one SWITCH cycle; no backpressure.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH:0]   load_len,
  output logic                  rom_rd_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [DATA_WIDTH-1:0] imem_wr_data,
  input  logic                  hlt,
  input  logic                  resume,
  output logic                  fetch_sel,
  output logic                  pc_hold,
  output logic                  pc_clear,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic                  fetch_sel_q, fetch_sel_d;

  logic [ADDR_WIDTH:0]   len_clamped;
  logic                  rd_issue;
  logic                  last_rd;
  logic                  wr_vld;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  wr_pend;

  // Any length with the top bit set is at least a full memory; copy exactly one.
  assign len_clamped = load_len[ADDR_WIDTH] ? CNT_MAX : load_len;
  assign rd_issue    = (state_q == ST_LOAD);
  assign last_rd     = (idx_q == (cnt_q - CNT_ONE));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    fetch_sel_d = fetch_sel_q;
    case (state_q)
      ST_BIOS: begin
        if (load_req) begin
          base_d  = load_base;
          cnt_d   = len_clamped;
          idx_d   = '0;
          state_d = (len_clamped == '0) ? ST_SWITCH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_d = idx_q + CNT_ONE;
        if (last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN:  if (!wr_pend) state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_RUN;
      ST_RUN:    if (hlt) state_d = ST_HALT;
      ST_HALT:   if (!hlt && resume) state_d = ST_RUN;
      default:   state_d = ST_BIOS;
    endcase
    // Raised on entry to SWITCH so it coincides with the pc_clear pulse.
    if (state_d == ST_SWITCH) fetch_sel_d = FETCH_IMEM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BIOS;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      fetch_sel_q <= FETCH_BIOS;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      fetch_sel_q <= fetch_sel_d;
    end
  end

  boot_copy_pipe #(
    .LAT (ROM_LATENCY),
    .AW  (ADDR_WIDTH)
  ) u_copy_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (rd_issue),
    .idx_i  (idx_q[ADDR_WIDTH-1:0]),
    .vld_o  (wr_vld),
    .idx_o  (wr_idx),
    .pend_o (wr_pend)
  );

  assign rom_rd_en    = rd_issue;
  assign rom_addr     = rd_issue ? (base_q + idx_q[ADDR_WIDTH-1:0]) : '0;
  assign imem_wr_en   = wr_vld;
  assign imem_wr_addr = wr_vld ? wr_idx : '0;
  assign imem_wr_data = wr_vld ? rom_rd_data : '0;

  assign fetch_sel = fetch_sel_q;
  assign pc_hold   = (state_q == ST_LOAD) || (state_q == ST_DRAIN) ||
                     (state_q == ST_SWITCH) || (state_q == ST_HALT);
  assign pc_clear  = (state_q == ST_SWITCH);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_DRAIN) ||
                     (state_q == ST_SWITCH);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: one instance at ROM latency 1, one at latency 3,
// sharing stimulus, each fed by a small ROM model returning 0xC0DE0000 | address.
module tb_boot_sequencer;

  typedef struct packed {
    logic [2:0] st;
    logic       rd;
    logic [9:0] ra;
    logic       wr;
    logic [9:0] wa;
    logic       clr;
    logic       fs;
    logic       hold;
    logic       busy;
  } row_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [9:0]  load_base;
  logic [10:0] load_len;
  logic        hlt;
  logic        resume;

  logic        rd1, wr1, fs1, hold1, clr1, busy1;
  logic [9:0]  addr1, waddr1;
  logic [31:0] rdata1, wdata1;
  logic [2:0]  st1;
  logic        rd3, wr3, fs3, hold3, clr3, busy3;
  logic [9:0]  addr3, waddr3;
  logic [31:0] rdata3, wdata3;
  logic [2:0]  st3;

  logic [60:0] all1, all3;
  logic [9:0]  a1_q;
  logic [9:0]  a3_q [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  boot_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ROM_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .load_req(load_req), .load_base(load_base), .load_len(load_len),
    .rom_rd_en(rd1), .rom_addr(addr1), .rom_rd_data(rdata1),
    .imem_wr_en(wr1), .imem_wr_addr(waddr1), .imem_wr_data(wdata1),
    .hlt(hlt), .resume(resume), .fetch_sel(fs1), .pc_hold(hold1), .pc_clear(clr1),
    .busy(busy1), .state_dbg(st1)
  );

  boot_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ROM_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .load_req(load_req), .load_base(load_base), .load_len(load_len),
    .rom_rd_en(rd3), .rom_addr(addr3), .rom_rd_data(rdata3),
    .imem_wr_en(wr3), .imem_wr_addr(waddr3), .imem_wr_data(wdata3),
    .hlt(hlt), .resume(resume), .fetch_sel(fs3), .pc_hold(hold3), .pc_clear(clr3),
    .busy(busy3), .state_dbg(st3)
  );

  // ROM models: data appears 1 (resp. 3) cycles after the address is presented.
  always @(posedge clk) begin
    a1_q    <= addr1;
    a3_q[0] <= addr3;
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign rdata1 = 32'hC0DE_0000 | {22'd0, a1_q};
  assign rdata3 = 32'hC0DE_0000 | {22'd0, a3_q[2]};

  assign all1 = {rd1, addr1, wr1, waddr1, wdata1, fs1, hold1, clr1, busy1, st1};
  assign all3 = {rd3, addr3, wr3, waddr3, wdata3, fs3, hold3, clr3, busy3, st3};

  function automatic row_t mk(input int st, input int rd, input int ra, input int wr,
                              input int wa, input int clr, input int fs, input int hold,
                              input int busy);
    row_t r;
    r.st = 3'(st);  r.rd = 1'(rd);   r.ra = 10'(ra);   r.wr = 1'(wr);  r.wa = 10'(wa);
    r.clr = 1'(clr); r.fs = 1'(fs);  r.hold = 1'(hold); r.busy = 1'(busy);
    return r;
  endfunction

  function automatic row_t obs1();
    row_t r;
    r.st = st1;  r.rd = rd1;  r.ra = rd1 ? addr1 : 10'd0;  r.wr = wr1;  r.wa = wr1 ? waddr1 : 10'd0;
    r.clr = clr1; r.fs = fs1; r.hold = hold1; r.busy = busy1;
    return r;
  endfunction

  function automatic row_t obs3();
    row_t r;
    r.st = st3;  r.rd = rd3;  r.ra = rd3 ? addr3 : 10'd0;  r.wr = wr3;  r.wa = wr3 ? waddr3 : 10'd0;
    r.clr = clr3; r.fs = fs3; r.hold = hold3; r.busy = busy3;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0; load_req = 1'b0; load_base = '0; load_len = '0; hlt = 1'b0; resume = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load_req = 1'b1; load_base = 10'h155; load_len = 11'd7; hlt = 1'b1; resume = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (all1 !== 61'd0) begin failures++; $display("FAIL reset_lat1 got %h exp 0", all1); end
    checks++;
    if (all3 !== 61'd0) begin failures++; $display("FAIL reset_lat3 got %h exp 0", all3); end
    do_reset();
  endtask

  task automatic test_copy_lat1();
    row_t tbl [8];
    row_t got;
    tbl[0] = mk(0, 0, 0,      0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 1, 'h010,  0, 0, 0, 0, 1, 1);
    tbl[2] = mk(1, 1, 'h011,  1, 0, 0, 0, 1, 1);
    tbl[3] = mk(1, 1, 'h012,  1, 1, 0, 0, 1, 1);
    tbl[4] = mk(1, 1, 'h013,  1, 2, 0, 0, 1, 1);
    tbl[5] = mk(2, 0, 0,      1, 3, 0, 0, 1, 1);
    tbl[6] = mk(3, 0, 0,      0, 0, 1, 1, 1, 1);
    tbl[7] = mk(4, 0, 0,      0, 0, 0, 1, 0, 0);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      load_req = (c == 0); load_base = 10'h010; load_len = 11'd4;
      #1;
      got = obs1();
      checks++;
      if (got !== tbl[c]) begin
        failures++; $display("FAIL copy_lat1 cycle %0d got %h exp %h", c, got, tbl[c]);
      end
      if (tbl[c].wr) begin
        checks++;
        if (wdata1 !== (32'hC0DE_0000 | {22'd0, 10'h010 + tbl[c].wa})) begin
          failures++; $display("FAIL copy_lat1_data cycle %0d got %h", c, wdata1);
        end
      end
    end
  endtask

  task automatic test_copy_lat3_wrap();
    row_t tbl [10];
    row_t got;
    tbl[0] = mk(0, 0, 0,      0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 1, 'h3FE,  0, 0, 0, 0, 1, 1);
    tbl[2] = mk(1, 1, 'h3FF,  0, 0, 0, 0, 1, 1);
    tbl[3] = mk(1, 1, 'h000,  0, 0, 0, 0, 1, 1);
    tbl[4] = mk(1, 1, 'h001,  1, 0, 0, 0, 1, 1);
    tbl[5] = mk(2, 0, 0,      1, 1, 0, 0, 1, 1);
    tbl[6] = mk(2, 0, 0,      1, 2, 0, 0, 1, 1);
    tbl[7] = mk(2, 0, 0,      1, 3, 0, 0, 1, 1);
    tbl[8] = mk(3, 0, 0,      0, 0, 1, 1, 1, 1);
    tbl[9] = mk(4, 0, 0,      0, 0, 0, 1, 0, 0);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      load_req = (c == 0); load_base = 10'h3FE; load_len = 11'd4;
      #1;
      got = obs3();
      checks++;
      if (got !== tbl[c]) begin
        failures++; $display("FAIL copy_lat3 cycle %0d got %h exp %h", c, got, tbl[c]);
      end
      if (tbl[c].wr) begin
        checks++;
        if (wdata3 !== (32'hC0DE_0000 | {22'd0, 10'h3FE + tbl[c].wa})) begin
          failures++; $display("FAIL copy_lat3_data cycle %0d got %h", c, wdata3);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    row_t tbl [3];
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(3, 0, 0, 0, 0, 1, 1, 1, 1);
    tbl[2] = mk(4, 0, 0, 0, 0, 0, 1, 0, 0);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      load_req = (c == 0); load_base = 10'h2A0; load_len = 11'd0;
      #1;
      checks++;
      if (obs1() !== tbl[c]) begin
        failures++; $display("FAIL zero_len_lat1 cycle %0d got %h exp %h", c, obs1(), tbl[c]);
      end
      checks++;
      if (obs3() !== tbl[c]) begin
        failures++; $display("FAIL zero_len_lat3 cycle %0d got %h exp %h", c, obs3(), tbl[c]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    row_t tbl [6];
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      load_req = (c == 0); load_base = 10'h100; load_len = 11'd8;
    end
    #1;
    checks++;
    if ({wr1, waddr1} !== {1'b1, 10'd2}) begin
      failures++; $display("FAIL third_write got wr=%b addr=%0d exp wr=1 addr=2", wr1, waddr1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (all1 !== 61'd0) begin failures++; $display("FAIL async_reset_lat1 got %h exp 0", all1); end
    checks++;
    if (all3 !== 61'd0) begin failures++; $display("FAIL async_reset_lat3 got %h exp 0", all3); end
    @(negedge clk);
    rst = 1'b1;
    tbl[0] = mk(0, 0, 0,     0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 1, 'h020, 0, 0, 0, 0, 1, 1);
    tbl[2] = mk(1, 1, 'h021, 1, 0, 0, 0, 1, 1);
    tbl[3] = mk(2, 0, 0,     1, 1, 0, 0, 1, 1);
    tbl[4] = mk(3, 0, 0,     0, 0, 1, 1, 1, 1);
    tbl[5] = mk(4, 0, 0,     0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      load_req = (c == 0); load_base = 10'h020; load_len = 11'd2;
      #1;
      checks++;
      if (obs1() !== tbl[c]) begin
        failures++; $display("FAIL restart cycle %0d got %h exp %h", c, obs1(), tbl[c]);
      end
      if (tbl[c].wr) begin
        checks++;
        if (wdata1 !== (32'hC0DE_0000 | {22'd0, 10'h020 + tbl[c].wa})) begin
          failures++; $display("FAIL restart_data cycle %0d got %h", c, wdata1);
        end
      end
    end
  endtask

  // Runs from the RUN state left behind by test_reset_mid_load.
  task automatic test_halt_resume();
    logic hl [5];
    logic rs [5];
    row_t tbl [5];
    hl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[0] = mk(4, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[1] = mk(5, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[2] = mk(5, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[3] = mk(4, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[4] = mk(4, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      load_req = 1'b0; hlt = hl[c]; resume = rs[c];
      #1;
      checks++;
      if (obs1() !== tbl[c]) begin
        failures++; $display("FAIL halt_resume step %0d got %h exp %h", c, obs1(), tbl[c]);
      end
    end
    hlt = 1'b0; resume = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    logic lr [10];
    logic hl [10];
    int   bs [10];
    int   ln [10];
    row_t tbl [10];
    lr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    hl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    bs = '{0, 'h040, 'h200, 0, 0, 0, 0, 'h300, 0, 0};
    ln = '{0, 3, 9, 0, 0, 0, 0, 5, 0, 0};
    tbl[0] = mk(0, 0, 0,     0, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 0, 0,     0, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 1, 'h040, 0, 0, 0, 0, 1, 1);
    tbl[3] = mk(1, 1, 'h041, 1, 0, 0, 0, 1, 1);
    tbl[4] = mk(1, 1, 'h042, 1, 1, 0, 0, 1, 1);
    tbl[5] = mk(2, 0, 0,     1, 2, 0, 0, 1, 1);
    tbl[6] = mk(3, 0, 0,     0, 0, 1, 1, 1, 1);
    tbl[7] = mk(4, 0, 0,     0, 0, 0, 1, 0, 0);
    tbl[8] = mk(5, 0, 0,     0, 0, 0, 1, 1, 0);
    tbl[9] = mk(5, 0, 0,     0, 0, 0, 1, 1, 0);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      load_req = lr[c]; hlt = hl[c]; load_base = 10'(bs[c]); load_len = 11'(ln[c]);
      #1;
      checks++;
      if (obs1() !== tbl[c]) begin
        failures++; $display("FAIL ignored cycle %0d got %h exp %h", c, obs1(), tbl[c]);
      end
    end
    hlt = 1'b0; load_req = 1'b0;
  endtask

  task automatic test_len_clamp();
    int   nrd = 0;
    int   nwr = 0;
    int   bad = 0;
    logic done = 1'b0;
    logic [9:0] last_wa = '0;
    do_reset();
    @(negedge clk);
    load_req = 1'b1; load_base = 10'h000; load_len = 11'h500;
    for (int n = 0; n < 1200 && !done; n++) begin
      @(negedge clk);
      load_req = 1'b0;
      #1;
      if (rd1) begin
        if (addr1 !== 10'(nrd)) bad++;
        nrd++;
      end
      if (wr1) begin
        nwr++;
        last_wa = waddr1;
      end
      if (st1 == 3'd4) done = 1'b1;
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL clamp_reach_run got %b exp 1", done); end
    checks++;
    if (nrd != 1024) begin failures++; $display("FAIL clamp_reads got %0d exp 1024", nrd); end
    checks++;
    if (nwr != 1024) begin failures++; $display("FAIL clamp_writes got %0d exp 1024", nwr); end
    checks++;
    if (last_wa !== 10'h3FF) begin failures++; $display("FAIL clamp_last_addr got %h exp 3ff", last_wa); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL clamp_addr_seq got %0d bad exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_copy_lat1();
    test_copy_lat3_wrap();
    test_zero_len();
    test_reset_mid_load();
    test_halt_resume();
    test_ignored_inputs();
    test_len_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
- Sequences the core's boot: while running from BIOS, on request copies a program image from boot ROM into instruction memory, then hands instruction fetch over to instruction memory.
- Drives the fetch-source mux select, the PC hold/clear controls and the instruction-memory write port.
- After handover, the sequencer owns halt/resume of the core.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 10, word address width of boot ROM and instruction memory.
- ROM_LATENCY, 1, boot ROM read latency in cycles (legal range 1..4).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_req  in  1  single-cycle request from BIOS to start the copy.
- load_base  in  ADDR_WIDTH  boot ROM start address; sampled with load_req.
- load_len  in  ADDR_WIDTH+1  word count; sampled with load_req.
- rom_rd_en  out  1  boot ROM read strobe.
- rom_addr  out  ADDR_WIDTH  boot ROM read address.
- rom_rd_data  in  DATA_WIDTH  boot ROM data; valid ROM_LATENCY cycles after rom_rd_en.
- imem_wr_en  out  1  instruction memory write strobe.
- imem_wr_addr  out  ADDR_WIDTH  instruction memory write address.
- imem_wr_data  out  DATA_WIDTH  instruction memory write data.
- hlt  in  1  halt request from the core.
- resume  in  1  resume request from the debug/IO side.
- fetch_sel  out  1  0 = BIOS instruction, 1 = instruction memory instruction.
- pc_hold  out  1  freezes the PC.
- pc_clear  out  1  single-cycle PC reset to 0 at handover.
- busy  out  1  high in LOAD, DRAIN and SWITCH.
- state_dbg  out  3  encoded current state.

Behaviour:
- Reset (rst=0, asynchronous): state BIOS; every output 0, including fetch_sel.
- Reset mid-load aborts the copy. Instruction memory keeps any partial contents; fetch returns to BIOS.
- BIOS (0):
  - pc_hold=0.
  - load_req=1: latch base and count, clamping the count to 2^ADDR_WIDTH, and clear the index.
  - Go to LOAD, or to SWITCH if the count is 0.
- LOAD (1):
  - pc_hold=1; one read per cycle: rom_rd_en=1, rom_addr=(base+i) mod 2^ADDR_WIDTH.
  - First read occurs the cycle after load_req.
  - After issuing read count-1, go to DRAIN.
- Write path:
  - Each read's index travels a ROM_LATENCY-deep valid/index delay line.
  - When the delayed valid is set: imem_wr_en=1, imem_wr_addr=index, imem_wr_data=rom_rd_data.
  - Instruction memory is always written from address 0.
- DRAIN (2): no reads; wait until the delay line is empty (last write done), then go to SWITCH.
- SWITCH (3): exactly one cycle; pc_clear=1 and fetch_sel is set to 1; go to RUN.
  - fetch_sel is sticky: once set, it stays 1 until reset.
- RUN (4): pc_hold=0; hlt=1 goes to HALT.
- HALT (5):
  - pc_hold=1; resume=1 with hlt=0 returns to RUN.
  - hlt and resume both high: remain in HALT (hlt has priority).
- Ignored inputs:
  - load_req outside BIOS is ignored.
  - hlt and resume are ignored outside RUN/HALT; a hlt held high on entry to RUN halts the next cycle.
- Latency: copying N words takes N+ROM_LATENCY cycles from the first read to the last write, plus 1 SWITCH cycle.

Decomposition:
- Package boot_seq_pkg holds:
  - state encoding constants ST_BIOS..ST_HALT;
  - FETCH_BIOS=0, FETCH_IMEM=1;
  - the ROM_LATENCY bound.
- Sub-module boot_copy_pipe holds the parameterised valid/index delay line of depth ROM_LATENCY.

Test Plan:
- Reset, then load_req with base=0x010 and len=4 (ROM_LATENCY=1) -> reads at 0x010..0x013 on consecutive cycles; writes to 0..3 each one cycle later; one pc_clear pulse; fetch_sel=1 after 6 cycles.
- ROM_LATENCY=3, base=0x3FE, len=4 -> rom_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; writes 0..3 with 3-cycle lag; DRAIN lasts 3 cycles.
- load_req with len=0 -> no reads or writes; SWITCH the next cycle; pc_clear=1; fetch_sel=1.
- rst=0 asserted asynchronously on the 3rd write of len=8 -> all outputs 0 immediately, state_dbg=0; a later load_req restarts the copy cleanly.
- In RUN: hlt=1 -> HALT with pc_hold=1; hlt=1 and resume=1 together -> stays HALT; resume=1 with hlt=0 -> RUN.
- load_req pulsed during LOAD and during RUN -> ignored; count and addresses are unchanged.
